// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter among NREQ byte
//            requesters; optional frame timeout when UART_ARB_TIMEOUT_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int IDW           = 2,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              enable,
  input  logic              flush,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    cur_id,
  output logic              arb_busy,
  output logic              err,
  input  logic              baud_tick,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_en,
  output logic              tx_rst,
  output logic [7:0]        tx_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_last, w_last_nxt;
  logic            r_seen_busy, w_seen_busy_nxt;
  logic [NREQ-1:0] w_gnt_nxt, w_ack_nxt;
  logic [IDW-1:0]  w_cur_id_nxt;
  logic            w_err_nxt, w_tx_en_nxt, w_tx_rst_nxt;
  logic [7:0]      w_tx_data_nxt, w_sel_byte;
  logic            w_found, w_complete, w_timeout;
  logic [IDW-1:0]  w_winner;

  // First pending request strictly after the last served one, wrapping at NREQ
  always_comb begin : p_pick
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && ((req >> idx) & NREQ'(1)) != '0) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  assign w_sel_byte = 8'(req_data >> (8 * w_winner));
  // A tx_done left over from the previous frame is ignored until busy was seen
  assign w_complete = r_seen_busy && !tx_busy && tx_done;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_TICKS + 1);
  logic [c_CNT_W-1:0] r_tick_cnt, w_tick_cnt_nxt;

  assign w_timeout = (r_state == SEND) && (r_tick_cnt == c_CNT_W'(TIMEOUT_TICKS));

  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt;
    if (r_state == LOAD)
      w_tick_cnt_nxt = '0;
    else if (r_state == SEND && baud_tick && !w_timeout)
      w_tick_cnt_nxt = r_tick_cnt + c_CNT_W'(1);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_tick_cnt <= '0;
    else          r_tick_cnt <= w_tick_cnt_nxt;
  end
`else
  localparam int c_unused_timeout = TIMEOUT_TICKS;
  logic w_unused_tick;
  assign w_unused_tick = baud_tick;
  assign w_timeout     = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_seen_busy_nxt = r_seen_busy;
    w_gnt_nxt       = gnt;
    w_ack_nxt       = '0;
    w_cur_id_nxt    = cur_id;
    w_err_nxt       = 1'b0;
    w_tx_en_nxt     = tx_en;
    w_tx_rst_nxt    = flush;
    w_tx_data_nxt   = tx_data;
    case (r_state)
      IDLE: if (enable && w_found) begin
        w_tx_data_nxt = w_sel_byte;
        w_gnt_nxt     = NREQ'(1) << w_winner;
        w_cur_id_nxt  = w_winner;
        w_state_nxt   = LOAD;
      end
      LOAD: begin
        w_tx_en_nxt     = 1'b1;
        w_seen_busy_nxt = 1'b0;
        w_state_nxt     = SEND;
      end
      SEND: begin
        if (tx_busy) w_seen_busy_nxt = 1'b1;
        if (w_complete) begin
          w_tx_en_nxt = 1'b0;
          w_ack_nxt   = NREQ'(1) << cur_id;
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          w_tx_rst_nxt = 1'b1;
          w_tx_en_nxt  = 1'b0;
          w_ack_nxt    = NREQ'(1) << cur_id;
          w_err_nxt    = 1'b1;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        w_last_nxt  = cur_id;
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort keeps last grant so the flushed requester retains its priority
    if (flush && r_state != IDLE) begin
      w_state_nxt = IDLE;
      w_tx_en_nxt = 1'b0;
      w_gnt_nxt   = '0;
      w_ack_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_last_nxt  = r_last;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_last      <= IDW'(NREQ - 1);
      r_seen_busy <= 1'b0;
      gnt         <= '0;
      ack         <= '0;
      cur_id      <= '0;
      arb_busy    <= 1'b0;
      err         <= 1'b0;
      tx_en       <= 1'b0;
      tx_rst      <= 1'b0;
      tx_data     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_seen_busy <= w_seen_busy_nxt;
      gnt         <= w_gnt_nxt;
      ack         <= w_ack_nxt;
      cur_id      <= w_cur_id_nxt;
      arb_busy    <= (w_state_nxt != IDLE);
      err         <= w_err_nxt;
      tx_en       <= w_tx_en_nxt;
      tx_rst      <= w_tx_rst_nxt;
      tx_data     <= w_tx_data_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter among NREQ byte-producing requesters. It selects a requester, presents its byte on tx_data, and gates tx_en for exactly one 10-bit frame. It tracks frame progress through tx_busy/tx_done and returns a per-requester completion ack. It sits between the APB-side producers and the UART module, in the PCLK domain.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of cur_id; must equal clog2(NREQ)
TIMEOUT_TICKS, 16, baud ticks allowed per frame before abort (used only with the optional feature)

Ports:
PCLK  in  1  system clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
enable  in  1  permits new grants; an in-flight frame always finishes
flush  in  1  one-cycle abort request
req  in  NREQ  request per requester; level; held until ack
req_data  in  8*NREQ  byte per requester; requester i uses [8i+7:8i]
gnt  out  NREQ  one-hot grant, held for the whole frame
ack  out  NREQ  one-cycle completion pulse to the granted requester
cur_id  out  IDW  index of the granted requester
arb_busy  out  1  high in any state except IDLE
err  out  1  one-cycle timeout pulse, coincident with ack
baud_tick  in  1  same tick that feeds the UART
tx_busy  in  1  from UART
tx_done  in  1  from UART
tx_en  out  1  to UART
tx_rst  out  1  to UART; one-cycle pulse
tx_data  out  8  to UART

Behaviour:
- Reset values: gnt=0, ack=0, cur_id=0, arb_busy=0, err=0, tx_en=0, tx_rst=0, tx_data=0x00, last_grant=NREQ-1, so requester 0 wins first. All outputs are registered.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - If enable and |req: the winner is the first set req bit searching upward from last_grant+1, wrapping from NREQ-1 to 0.
  - On the same edge: tx_data<=req_data[winner], gnt<=onehot(winner), cur_id<=winner. Go to LOAD.
- LOAD:
  - Lasts exactly one cycle, so the UART captures tx_data while its tx_busy is 0.
  - tx_en<=1. Clear seen_busy. Go to SEND.
- SEND:
  - tx_en stays 1.
  - tx_busy==1 sets seen_busy.
  - Completion is seen_busy && !tx_busy && tx_done. On completion: tx_en<=0 on the same edge, go to DONE.
  - A stale tx_done from the previous frame is ignored because seen_busy is still 0.
- DONE:
  - Lasts one cycle. ack[cur_id]=1 for this cycle only. last_grant<=cur_id, gnt<=0, go to IDLE.
  - The earliest next grant is the cycle after DONE.
- Latency: grant to tx_en is 1 cycle. Last baud_tick to ack is 2 cycles.
- baud_tick spacing must be at least 4 PCLK. This guarantees tx_en drops before the next tick, so the UART never starts a second frame.
- req deasserted mid-frame: ignored; the frame completes and ack still pulses.
- req_data is sampled only at grant.
- enable low mid-frame: the frame completes with ack; no new grant is issued while enable is low.
- flush in any non-IDLE state:
  - Next edge: tx_rst=1 for one cycle, tx_en<=0, gnt<=0, go to IDLE.
  - No ack. last_grant is unchanged, so the flushed requester keeps its priority.
  - flush in IDLE: tx_rst pulses; no other effect.
  - flush and completion in the same cycle: flush wins.
- Asynchronous reset mid-frame returns every output and state to its reset value immediately.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A tick counter sized for TIMEOUT_TICKS clears in LOAD and increments on each baud_tick in SEND.
  - When it reaches TIMEOUT_TICKS without completion: tx_rst pulses for one cycle, tx_en<=0, and the FSM goes to DONE.
  - DONE then asserts ack[cur_id] and err together for one cycle, and last_grant advances.
- Not defined: no counter; err is tied to 0; SEND waits indefinitely.

Test Plan:
1. After reset, req=0010, req_data[15:8]=0xA5, enable=1, baud_tick every 8 PCLK -> gnt=0010, cur_id=1, tx_data=0xA5; TX bits are 0,1,0,1,0,0,1,0,1,1; ack=0010 for exactly 1 cycle, 2 cycles after the 10th tick.
2. req=1111 held from reset, each requester dropping req after its ack -> grant order 0,1,2,3; each ack bit pulses exactly once; arb_busy=0 only between frames.
3. Grant to 3 completes while req=1001 -> next gnt=0001 (wrap from 3 to 0).
4. enable dropped after the 3rd tick of a frame for requester 2 with req=0110 -> frame finishes, ack=0100, no further gnt while enable=0.
5. flush after the 5th tick of a frame for requester 1 -> tx_rst high 1 cycle, tx_en=0, no ack; with req=0010 still high, requester 1 is regranted next.
6. With UART_ARB_TIMEOUT_EN, a UART model holding tx_busy=0, req=0001 -> after 16 ticks tx_rst pulses, then ack=0001 and err=1 in the same cycle; without the macro, no ack and arb_busy stays 1.
